// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int WIDTH_DEFAULT = 8;

   // Bit count needed to hold values 0..w
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational one-bit full adder cell.
module fa_bit_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one WIDTH-bit add of a + b + c_in, LSB first, one bit per clock,
// through a single fa_bit_cell instance.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_r;
   state_t           state_s;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   // The bit leaving the bottom of the sum shifter is always discarded, so only the upper bits are stored
   logic [WIDTH-1:1] s_sr_r;
   logic [WIDTH-1:0] s_next_s;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;
   logic             fa_s_s;
   logic             fa_co_s;
   logic             accept_s;
   logic             last_s;

   fa_bit_cell u_fa (
      .a  (a_sr_r[0]),
      .b  (b_sr_r[0]),
      .ci (carry_r),
      .s  (fa_s_s),
      .co (fa_co_s)
   );

   assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign last_s   = (cnt_r == CW'(WIDTH - 1));
   assign s_next_s = {fa_s_s, s_sr_r};
   assign busy     = (state_r == ST_RUN);
   assign done     = (state_r == ST_DONE);

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_s = ST_RUN;
            else       state_s = ST_IDLE;
         end
         ST_RUN: begin
            if (last_s) state_s = ST_DONE;
            else        state_s = ST_RUN;
         end
         ST_DONE: begin
            if (start) state_s = ST_RUN;
            else       state_s = ST_IDLE;
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_s;
   end

   // Operand shifters, carry flop, bit counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr_r  <= {WIDTH{1'b0}};
         b_sr_r  <= {WIDTH{1'b0}};
         s_sr_r  <= {(WIDTH-1){1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         sum     <= {WIDTH{1'b0}};
         c_out   <= 1'b0;
      end else if (accept_s) begin
         a_sr_r  <= a;
         b_sr_r  <= b;
         carry_r <= c_in;
         cnt_r   <= {CW{1'b0}};
      end else if (state_r == ST_RUN) begin
         a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
         b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
         s_sr_r  <= s_next_s[WIDTH-1:1];
         carry_r <= fa_co_s;
         cnt_r   <= cnt_r + CW'(1);
         if (last_s) begin
            sum   <= s_next_s;
            c_out <= fa_co_s;
         end
      end
   end

endmodule
